// File: rtl/ram_pg_partition_ctrl_if.sv
// Configuration, pipeline-write and RAM write-port bundle for ram_pg_partition_ctrl.
// The controller uses the slave view. A pipeline or testbench uses the master view.
interface ram_pg_partition_ctrl_if #(
  parameter int NUM_PART = 4,
  parameter int INDEX    = 6,
  parameter int WIDTH    = 32
);
  logic                cfgValid_i;
  logic [NUM_PART-1:0] cfgMask_i;
  logic                cfgReady_o;
  logic [NUM_PART-1:0] pwrGate_o;
  logic [NUM_PART-1:0] partReady_o;
  logic                we_i;
  logic [INDEX-1:0]    addrWr_i;
  logic [WIDTH-1:0]    data_i;
  logic                wrStall_o;
  logic                wrErr_o;
  logic                ramWe_o;
  logic [INDEX-1:0]    ramAddrWr_o;
  logic [WIDTH-1:0]    ramData_o;

  modport slave (
    input  cfgValid_i, cfgMask_i, we_i, addrWr_i, data_i,
    output cfgReady_o, pwrGate_o, partReady_o, wrStall_o, wrErr_o,
           ramWe_o, ramAddrWr_o, ramData_o
  );

  modport master (
    output cfgValid_i, cfgMask_i, we_i, addrWr_i, data_i,
    input  cfgReady_o, pwrGate_o, partReady_o, wrStall_o, wrErr_o,
           ramWe_o, ramAddrWr_o, ramData_o
  );
endinterface

// File: rtl/ram_pg_partition_ctrl.sv
// Power-gate sequencer and write-port owner for a partitioned 1R1W RAM.
// On a new mask it gates, then wakes, then re-initialises partitions, and it arbitrates the RAM port.
module ram_pg_partition_ctrl #(
  parameter int NUM_PART    = 4,
  parameter int PART_BITS   = 2,
  parameter int INDEX       = 6,
  parameter int WIDTH       = 32,
  parameter int WAKE_CYCLES = 4,
  parameter int INIT_MODE   = 2,
  parameter int SEQ_START   = 0
) (
  input logic                   clk,
  input logic                   reset,
  ram_pg_partition_ctrl_if.slave bus
);
  localparam int ENTRY_BITS = INDEX - PART_BITS;
  localparam int WCW        = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, GATE, WAKE, INIT} state_t;

  state_t                state, state_nxt;
  logic [NUM_PART-1:0]   active, on_mask, pending, pwr_gate, part_ready;
  logic [NUM_PART-1:0]   off_req, on_req, part_onehot;
  logic [WCW-1:0]        wake_cnt;
  logic [ENTRY_BITS-1:0] entry;
  logic [PART_BITS-1:0]  init_part, wr_part;
  logic [INDEX-1:0]      init_addr;
  logic [WIDTH-1:0]      init_data;
  logic                  cfg_take, init_last, init_done;

  // The lowest pending partition is refilled first, so the refill order is ascending.
  always_comb begin
    init_part = '0;
    for (int unsigned i = NUM_PART; i > 0; i--) begin
      if (pending[i-1]) init_part = PART_BITS'(i - 1);
    end
  end

  always_comb begin
    off_req     = active & ~bus.cfgMask_i;
    on_req      = ~active & bus.cfgMask_i;
    cfg_take    = (state == IDLE) && bus.cfgValid_i && (bus.cfgMask_i != active);
    part_onehot = NUM_PART'(1) << init_part;
    init_last   = (entry == '1);
    init_done   = init_last && ((pending & ~part_onehot) == '0);
    init_addr   = {init_part, entry};
    init_data   = (INIT_MODE == 2) ? (WIDTH'(SEQ_START) + WIDTH'(init_addr)) : '0;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (cfg_take) state_nxt = GATE;
      GATE: state_nxt = (on_mask != '0) ? WAKE : IDLE;
      WAKE: if (wake_cnt == '0) state_nxt = (INIT_MODE == 0) ? IDLE : INIT;
      INIT: if (init_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      active     <= '1;
      on_mask    <= '0;
      pending    <= '0;
      pwr_gate   <= '0;
      part_ready <= '1;
      wake_cnt   <= '0;
      entry      <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (cfg_take) begin
            active     <= bus.cfgMask_i;
            on_mask    <= on_req;
            pwr_gate   <= pwr_gate | off_req;
            part_ready <= part_ready & ~off_req;
          end
        end
        GATE: begin
          if (on_mask != '0) begin
            pwr_gate <= pwr_gate & ~on_mask;
            wake_cnt <= WCW'(WAKE_CYCLES - 1);
          end
        end
        WAKE: begin
          if (wake_cnt == '0) begin
            if (INIT_MODE == 0) part_ready <= part_ready | on_mask;
            else begin
              pending <= on_mask;
              entry   <= '0;
            end
          end else begin
            wake_cnt <= wake_cnt - 1'b1;
          end
        end
        INIT: begin
          entry <= entry + 1'b1;
          if (init_last) pending <= pending & ~part_onehot;
          if (init_done) part_ready <= part_ready | on_mask;
        end
        default: ;
      endcase
    end
  end

  // The init write always owns the port. Writes to a partition that is not ready are dropped.
  always_comb begin
    wr_part         = bus.addrWr_i[INDEX-1 -: PART_BITS];
    bus.cfgReady_o  = (state == IDLE);
    bus.pwrGate_o   = pwr_gate;
    bus.partReady_o = part_ready;
    bus.wrStall_o   = 1'b0;
    bus.wrErr_o     = 1'b0;
    bus.ramWe_o     = 1'b0;
    bus.ramAddrWr_o = bus.addrWr_i;
    bus.ramData_o   = bus.data_i;
    if (state == INIT) begin
      bus.ramWe_o     = 1'b1;
      bus.ramAddrWr_o = init_addr;
      bus.ramData_o   = init_data;
      bus.wrStall_o   = bus.we_i;
    end else if (bus.we_i) begin
      if (part_ready[wr_part]) bus.ramWe_o = 1'b1;
      else                     bus.wrErr_o = 1'b1;
    end
  end
endmodule

// File: tb/tb_ram_pg_partition_ctrl.sv
// Randomised bench for ram_pg_partition_ctrl against a phase-by-cycle model of the
// reconfiguration sequence and the write-port arbitration.
module tb_ram_pg_partition_ctrl;
  localparam int WAKE = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] act;

  always #5 clk = ~clk;

  ram_pg_partition_ctrl_if #(.NUM_PART(4), .INDEX(6), .WIDTH(32)) bus ();

  ram_pg_partition_ctrl #(
    .NUM_PART(4), .PART_BITS(2), .INDEX(6), .WIDTH(32),
    .WAKE_CYCLES(WAKE), .INIT_MODE(2), .SEQ_START(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.pwrGate_o !== 4'b0000) begin errors++; $display("FAIL reset_pwrGate got %b exp 0000", bus.pwrGate_o); end
    checks++;
    if (bus.partReady_o !== 4'b1111) begin errors++; $display("FAIL reset_partReady got %b exp 1111", bus.partReady_o); end
    checks++;
    if (bus.cfgReady_o !== 1'b1) begin errors++; $display("FAIL reset_cfgReady got %b exp 1", bus.cfgReady_o); end
    checks++;
    if (bus.ramWe_o !== 1'b0 || bus.wrStall_o !== 1'b0 || bus.wrErr_o !== 1'b0) begin
      errors++; $display("FAIL reset_wrport got we=%b stall=%b err=%b exp 0 0 0", bus.ramWe_o, bus.wrStall_o, bus.wrErr_o);
    end
    act = 4'b1111;
  endtask

  // Offers a mask in IDLE, then follows every cycle until the first IDLE cycle afterwards.
  task automatic test_reconfig(input logic [3:0] mask, input bit hold,
                               input logic [5:0] h_addr, input logic [31:0] h_data);
    logic [3:0]  off, on, rdy_e, gate_e;
    logic [5:0]  wq[$];
    logic [5:0]  a_e;
    logic [31:0] d_e;
    logic        cr_e, we_e, st_e, er_e, init_ph;
    bit          noop;
    int          total;
    noop = (mask == act);
    off  = act & ~mask;
    on   = ~act & mask;
    for (int p = 0; p < 4; p++)
      if (on[p]) for (int e = 0; e < 16; e++) wq.push_back(6'(p * 16 + e));
    total = noop ? 0 : ((on != 4'b0) ? 1 + WAKE + wq.size() : 1);
    for (int k = 0; k <= total + 1; k++) begin
      @(negedge clk);
      bus.cfgValid_i = (k == 0) ? 1'b1 : ((k <= total) ? 1'($urandom_range(0, 1)) : 1'b0);
      bus.cfgMask_i  = (k == 0) ? mask : 4'($urandom);
      bus.we_i       = hold ? 1'b1 : 1'($urandom_range(0, 1));
      bus.addrWr_i   = hold ? h_addr : 6'($urandom);
      bus.data_i     = hold ? h_data : $urandom;
      #1;
      init_ph = 1'b0;
      a_e = bus.addrWr_i;
      d_e = bus.data_i;
      if (noop || k == 0 || k == total + 1) begin
        rdy_e  = (k == total + 1 && !noop) ? mask : act;
        gate_e = ~rdy_e;
        cr_e   = 1'b1;
      end else begin
        rdy_e  = act & mask;
        gate_e = (k == 1) ? ~(act & mask) : ~mask;
        cr_e   = 1'b0;
        if (k > 1 + WAKE) begin
          init_ph = 1'b1;
          a_e = wq[k - 2 - WAKE];
          d_e = 32'(a_e);
        end
      end
      if (init_ph) begin
        we_e = 1'b1; st_e = bus.we_i; er_e = 1'b0;
      end else if (bus.we_i && rdy_e[bus.addrWr_i[5:4]]) begin
        we_e = 1'b1; st_e = 1'b0; er_e = 1'b0;
      end else begin
        we_e = 1'b0; st_e = 1'b0; er_e = bus.we_i;
      end
      checks++;
      if (bus.pwrGate_o !== gate_e) begin errors++; $display("FAIL cfg%b_k%0d_pwrGate got %b exp %b", mask, k, bus.pwrGate_o, gate_e); end
      checks++;
      if (bus.partReady_o !== rdy_e) begin errors++; $display("FAIL cfg%b_k%0d_partReady got %b exp %b", mask, k, bus.partReady_o, rdy_e); end
      checks++;
      if (bus.cfgReady_o !== cr_e) begin errors++; $display("FAIL cfg%b_k%0d_cfgReady got %b exp %b", mask, k, bus.cfgReady_o, cr_e); end
      checks++;
      if ({bus.ramWe_o, bus.wrStall_o, bus.wrErr_o} !== {we_e, st_e, er_e}) begin
        errors++; $display("FAIL cfg%b_k%0d_wrctl got we/stall/err=%b%b%b exp %b%b%b", mask, k,
                           bus.ramWe_o, bus.wrStall_o, bus.wrErr_o, we_e, st_e, er_e);
      end
      if (we_e) begin
        checks++;
        if (bus.ramAddrWr_o !== a_e || bus.ramData_o !== d_e) begin
          errors++; $display("FAIL cfg%b_k%0d_wrdata got %h/%h exp %h/%h", mask, k, bus.ramAddrWr_o, bus.ramData_o, a_e, d_e);
        end
      end
    end
    bus.we_i = 1'b0;
    if (!noop) act = mask;
  endtask

  task automatic test_drop_err();
    @(negedge clk);
    bus.we_i = 1'b1; bus.addrWr_i = 6'd60; bus.data_i = $urandom;
    #1;
    checks++;
    if ({bus.ramWe_o, bus.wrErr_o, bus.wrStall_o} !== 3'b010) begin
      errors++; $display("FAIL drop60 got we/err/stall=%b%b%b exp 010", bus.ramWe_o, bus.wrErr_o, bus.wrStall_o);
    end
    @(negedge clk);
    bus.addrWr_i = 6'd20;
    #1;
    checks++;
    if ({bus.ramWe_o, bus.wrErr_o, bus.ramAddrWr_o} !== {2'b10, 6'd20}) begin
      errors++; $display("FAIL write20 got we/err/addr=%b%b/%0d exp 10/20", bus.ramWe_o, bus.wrErr_o, bus.ramAddrWr_o);
    end
    @(negedge clk);
    bus.we_i = 1'b0;
    #1;
    checks++;
    if (bus.wrErr_o !== 1'b0) begin errors++; $display("FAIL err_pulse got %b exp 0", bus.wrErr_o); end
  endtask

  task automatic test_reset_mid_wake();
    @(negedge clk);
    bus.cfgValid_i = 1'b1; bus.cfgMask_i = 4'b1000; bus.we_i = 1'b0;
    @(negedge clk);
    bus.cfgValid_i = 1'b0;
    #1;
    checks++;
    if (bus.pwrGate_o !== ~(act & 4'b1000)) begin errors++; $display("FAIL rmw_gate got %b exp %b", bus.pwrGate_o, ~(act & 4'b1000)); end
    @(negedge clk);
    #1;
    checks++;
    if (bus.pwrGate_o !== 4'b0111) begin errors++; $display("FAIL rmw_wake1_gate got %b exp 0111", bus.pwrGate_o); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.pwrGate_o, bus.partReady_o, bus.cfgReady_o} !== {4'b0000, 4'b1111, 1'b1}) begin
      errors++; $display("FAIL rmw_after got gate=%b rdy=%b cr=%b exp 0000 1111 1", bus.pwrGate_o, bus.partReady_o, bus.cfgReady_o);
    end
    act = 4'b1111;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.ramWe_o !== 1'b0 || bus.cfgReady_o !== 1'b1) begin
        errors++; $display("FAIL rmw_noinit_%0d got we=%b cr=%b exp 0 1", i, bus.ramWe_o, bus.cfgReady_o);
      end
    end
  endtask

  task automatic test_random_cfg();
    for (int i = 0; i < 12; i++) begin
      if (($urandom % 5) == 0) test_reconfig(act, 1'b0, 6'd0, 32'd0);
      else                     test_reconfig(4'($urandom), 1'b0, 6'd0, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.cfgValid_i = 1'b0; bus.cfgMask_i = '0;
    bus.we_i = 1'b0; bus.addrWr_i = '0; bus.data_i = '0;
    act = 4'b1111;
    test_reset();
    test_reconfig(4'b0011, 1'b0, 6'd0, 32'd0);
    test_reconfig(4'b0111, 1'b1, 6'd5, 32'h0000_ABCD);
    test_drop_err();
    test_reconfig(4'b0111, 1'b0, 6'd0, 32'd0);
    test_reset_mid_wake();
    test_random_cfg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
